fp_divider: RTL and testbench

- Sequential IEEE-754 binary32 divider computing result = N / D.
- Uses restoring mantissa division, one quotient bit per enabled clock.
- Sits in the floating-point calculator datapath beside the add and multiply units.
- Operands are captured while load is high; computation runs while load is low and en is high.

---
 rtl/fp_div_pkg.sv | 39 +++
 rtl/fp_div_round.sv | 42 ++++
 rtl/fp_divider.sv | 94 +++++++++
 tb/tb_fp_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared constants, types and operand unpacking for the binary32 divider
package fp_div_pkg;
  localparam int BIAS   = 127;
  localparam int ITER   = 26;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int REM_W  = MANT_W + 1;
  localparam int Q_W    = ITER;
  localparam int XEXP_W = 10;
  localparam int CNT_W  = 5;

  localparam logic [31:0]      QNAN      = 32'h7FC00000;
  localparam logic [31:0]      POS_INF   = 32'h7F800000;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ROUND, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } ufloat_t;

  // Exponent 0 counts as zero, so subnormal operands are flushed.
  function automatic ufloat_t unpack(input logic [31:0] f);
    ufloat_t u;
    u.sign    = f[31];
    u.exp     = f[30:23];
    u.frac    = f[22:0];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == '1) && (u.frac == '0);
    u.is_nan  = (u.exp == '1) && (u.frac != '0);
    return u;
  endfunction
endpackage

// File: rtl/fp_div_round.sv
// rtl/fp_div_round.sv - normalize, round-to-nearest-even, range check and special-case mux
module fp_div_round
  import fp_div_pkg::*;
(
  input  logic                     sign,
  input  logic signed [XEXP_W-1:0] exp_in,
  input  logic [Q_W-1:0]           q,
  input  logic                     sticky,
  input  logic                     sp_nan,
  input  logic                     sp_inf,
  input  logic                     sp_zero,
  output logic [31:0]              result
);
  logic [Q_W-1:0]           qn;
  logic signed [XEXP_W-1:0] e_norm;
  logic signed [XEXP_W-1:0] e_rnd;
  logic [MANT_W:0]          m_rnd;
  logic [FRAC_W-1:0]        frac;
  logic                     round_up;

  always_comb begin
    result = '0;
    qn     = q;
    e_norm = exp_in;
    if (!q[Q_W-1]) begin
      qn     = {q[Q_W-2:0], 1'b0};
      e_norm = exp_in - 10'sd1;
    end
    // qn[1] is the guard bit; the round bit and remainder fold into sticky
    round_up = qn[1] & (qn[0] | sticky | qn[2]);
    m_rnd    = {1'b0, qn[Q_W-1:2]} + (MANT_W+1)'(round_up);
    frac     = m_rnd[MANT_W] ? m_rnd[MANT_W-1:1] : m_rnd[FRAC_W-1:0];
    e_rnd    = e_norm + $signed({{(XEXP_W-1){1'b0}}, m_rnd[MANT_W]});

    if (sp_nan)                result = QNAN;
    else if (sp_inf)           result = {sign, POS_INF[30:0]};
    else if (sp_zero)          result = {sign, 31'd0};
    else if (e_rnd >= 10'sd255) result = {sign, POS_INF[30:0]};
    else if (e_rnd <= 10'sd0)  result = {sign, 31'd0};
    else                       result = {sign, e_rnd[EXP_W-1:0], frac};
  end
endmodule

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - sequential binary32 divider, one restoring quotient bit per enabled clock
module fp_divider
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] N,
  input  logic [31:0] D,
  output logic [31:0] result
);
  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [REM_W-1:0]         rem;
  logic [MANT_W-1:0]        div;
  logic [Q_W-1:0]           q;
  logic                     sign;
  logic signed [XEXP_W-1:0] exp_r;
  logic                     sp_nan, sp_inf, sp_zero;
  logic [31:0]              rnd_result;
  logic [REM_W-1:0]         div_ext;
  ufloat_t                  un, ud;

  assign un      = unpack(N);
  assign ud      = unpack(D);
  assign div_ext = {1'b0, div};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUSY:    if (en && cnt == LAST_ITER) state_nxt = ROUND;
      ROUND:   if (en) state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (load) state_nxt = BUSY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      rem     <= '0;
      div     <= '0;
      q       <= '0;
      sign    <= 1'b0;
      exp_r   <= '0;
      sp_nan  <= 1'b0;
      sp_inf  <= 1'b0;
      sp_zero <= 1'b0;
      result  <= '0;
    end else if (load) begin
      sign    <= un.sign ^ ud.sign;
      exp_r   <= {2'b00, un.exp} - {2'b00, ud.exp} + XEXP_W'(BIAS);
      rem     <= {2'b01, un.frac};
      div     <= {1'b1, ud.frac};
      q       <= '0;
      cnt     <= '0;
      sp_nan  <= un.is_nan | ud.is_nan | (un.is_zero & ud.is_zero) | (un.is_inf & ud.is_inf);
      sp_inf  <= un.is_inf | ud.is_zero;
      sp_zero <= un.is_zero | ud.is_inf;
      result  <= '0;
    end else if (en) begin
      if (state == BUSY) begin
        // rem stays below 2*div, so the shifted value always fits REM_W bits
        if (rem >= div_ext) begin
          q   <= {q[Q_W-2:0], 1'b1};
          rem <= (rem - div_ext) << 1;
        end else begin
          q   <= {q[Q_W-2:0], 1'b0};
          rem <= rem << 1;
        end
        cnt <= cnt + 1'b1;
      end else if (state == ROUND) begin
        result <= rnd_result;
      end
    end
  end

  fp_div_round u_round (
    .sign    (sign),
    .exp_in  (exp_r),
    .q       (q),
    .sticky  (|rem),
    .sp_nan  (sp_nan),
    .sp_inf  (sp_inf),
    .sp_zero (sp_zero),
    .result  (rnd_result)
  );
endmodule

// File: tb/tb_fp_divider.sv
// tb/tb_fp_divider.sv - self-checking bench for fp_divider
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        en;
  logic        rst;
  logic        load;
  logic [31:0] N;
  logic [31:0] D;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs[14];

  fp_divider dut (
    .clk    (clk),
    .en     (en),
    .rst    (rst),
    .load   (load),
    .N      (N),
    .D      (D),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: result=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic apply(input logic [31:0] n, input logic [31:0] d);
    @(negedge clk);
    N = n; D = d; load = 1'b1; en = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Reference: exact integer quotient with wide precision, then RNE from the discarded bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    bit za, zb, ia, ib, na, nb;
    longint unsigned ma, mb, num, qq, rr, mant, low, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
    if (ia || zb) return {s, 8'hFF, 23'd0};
    if (za || ib) return {s, 31'd0};
    ma  = 64'(a[22:0]) + 64'd8388608;
    mb  = 64'(b[22:0]) + 64'd8388608;
    num = ma << 30;
    qq  = num / mb;
    rr  = num % mb;
    e   = ea - eb + 127;
    if (qq >= (64'd1 << 30)) sh = 7;
    else begin
      sh = 6;
      e  = e - 1;
    end
    mant = qq >> sh;
    low  = qq & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (low > half || (low == half && (rr != 0 || mant[0]))) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    f = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       begin e = 8'd255; f = '0; end
      3:       e = 8'($urandom_range(1, 10));
      4:       e = 8'($urandom_range(245, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] a, b, expv;
    int edges, budget;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
    vecs[2]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000};
    vecs[5]  = '{32'h00000000, 32'h00800000, 32'h00000000};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
    vecs[7]  = '{32'h7F000000, 32'h00800000, 32'h7F800000};
    vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    vecs[10] = '{32'h40000000, 32'hFF800000, 32'h80000000};
    vecs[11] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000};
    vecs[12] = '{32'h3F800000, 32'hBF800000, 32'hBF800000};
    vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000};

    rst = 1'b0; en = 1'b0; load = 1'b0; N = '0; D = '0;
    repeat (2) @(negedge clk);
    check("reset", result, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].n, vecs[i].d);
      repeat (26) @(negedge clk);
      check($sformatf("vec%0d_early", i), result, 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d", i), result, vecs[i].expv);
    end

    // DONE holds regardless of en
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("done_hold", result, 32'h00000000);
    apply(32'h40C00000, 32'h40000000);
    repeat (30) @(negedge clk);
    check("done_hold2", result, 32'h40400000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", result, 32'h0);
    rst = 1'b1;

    // en gap of 10 cycles mid-BUSY
    apply(32'h3F800000, 32'h40400000);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (16) @(negedge clk);
    check("gap_early", result, 32'h0);
    @(negedge clk);
    check("gap", result, 32'h3EAAAAAB);

    // reset aborts a running division
    apply(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid", result, 32'h0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_idle", result, 32'h0);

    // reload mid-BUSY restarts with new operands
    apply(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    apply(32'hC0F00000, 32'h40200000);
    repeat (26) @(negedge clk);
    check("reload_early", result, 32'h0);
    @(negedge clk);
    check("reload", result, 32'hC0400000);

    // load held over several cycles keeps the last operands
    @(negedge clk);
    N = 32'h40C00000; D = 32'h40000000; load = 1'b1; en = 1'b1;
    @(negedge clk);
    N = 32'h3F800000; D = 32'h40400000;
    @(negedge clk);
    load = 1'b0;
    repeat (26) @(negedge clk);
    check("hold_load_early", result, 32'h0);
    @(negedge clk);
    check("hold_load", result, 32'h3EAAAAAB);

    // randomized operands with random en gaps
    for (int i = 0; i < 150; i++) begin
      a    = rand_fp();
      b    = rand_fp();
      expv = ref_div(a, b);
      apply(a, b);
      edges  = 0;
      budget = 0;
      while (edges < 27 && budget < 400) begin
        en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        budget++;
        if (en) begin
          edges++;
          if (edges == 26) check($sformatf("rand_early %h/%h", a, b), result, 32'h0);
        end
      end
      if (edges < 27) begin
        compared++;
        mismatched++;
        $display("FAIL rand_timeout: enabled_edges=%0d expected=27", edges);
      end
      check($sformatf("rand %h/%h", a, b), result, expv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
